// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths and register index map for the CPU register file
package reg_file_pkg;

  localparam int DATA_BUS     = 16;
  localparam int REG_ADDR_BUS = 4;
  localparam int NUM_REGS     = 12;

  localparam logic [REG_ADDR_BUS-1:0] REG_R0   = 4'd0;
  localparam logic [REG_ADDR_BUS-1:0] REG_R1   = 4'd1;
  localparam logic [REG_ADDR_BUS-1:0] REG_R2   = 4'd2;
  localparam logic [REG_ADDR_BUS-1:0] REG_R3   = 4'd3;
  localparam logic [REG_ADDR_BUS-1:0] REG_R4   = 4'd4;
  localparam logic [REG_ADDR_BUS-1:0] REG_R5   = 4'd5;
  localparam logic [REG_ADDR_BUS-1:0] REG_R6   = 4'd6;
  localparam logic [REG_ADDR_BUS-1:0] REG_R7   = 4'd7;
  localparam logic [REG_ADDR_BUS-1:0] REG_SP   = 4'd8;
  localparam logic [REG_ADDR_BUS-1:0] REG_IH   = 4'd9;
  localparam logic [REG_ADDR_BUS-1:0] REG_RA   = 4'd10;
  localparam logic [REG_ADDR_BUS-1:0] REG_T    = 4'd11;
  localparam logic [REG_ADDR_BUS-1:0] REG_NONE = 4'd15;

  // Indices above T (reserved codes and NONE) have no backing storage.
  function automatic logic is_arch_reg(input logic [REG_ADDR_BUS-1:0] idx);
    return idx <= REG_T;
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - one combinational read port with write-through bypass
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DATA_BUS,
  parameter int RADDR_W = REG_ADDR_BUS
) (
  input  logic [RADDR_W-1:0]               addr,
  input  logic                             wb_en,
  input  logic [RADDR_W-1:0]               wb_reg,
  input  logic [DATA_W-1:0]                wb_data,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  output logic [DATA_W-1:0]                data
);

  always_comb begin
    data = '0;
    if (is_arch_reg(addr)) begin
      if (wb_en && (wb_reg == addr)) data = wb_data;
      else                           data = regs[addr];
    end
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 12-entry architectural register file with two bypassed read ports
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DATA_BUS,
  parameter int RADDR_W = REG_ADDR_BUS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic [RADDR_W-1:0] rx_addr,
  input  logic [RADDR_W-1:0] ry_addr,
  output logic [DATA_W-1:0]  rx_data,
  output logic [DATA_W-1:0]  ry_data,
  output logic [DATA_W-1:0]  ih_data,
  output logic [DATA_W-1:0]  sp_data,
  output logic               t_flag
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else if (wb_en && is_arch_reg(wb_reg)) begin
      regs[wb_reg] <= wb_data;
    end
  end

  reg_read_port #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_port_x (
    .addr    (rx_addr),
    .wb_en   (wb_en),
    .wb_reg  (wb_reg),
    .wb_data (wb_data),
    .regs    (regs),
    .data    (rx_data)
  );

  reg_read_port #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_port_y (
    .addr    (ry_addr),
    .wb_en   (wb_en),
    .wb_reg  (wb_reg),
    .wb_data (wb_data),
    .regs    (regs),
    .data    (ry_data)
  );

  // Side outputs see committed storage only, never the bypass.
  assign ih_data = regs[REG_IH];
  assign sp_data = regs[REG_SP];
  assign t_flag  = regs[REG_T][0];

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - vector table plus scoreboard bench for reg_file
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic [3:0]  rx_addr;
  logic [3:0]  ry_addr;
  logic [15:0] rx_data;
  logic [15:0] ry_data;
  logic [15:0] ih_data;
  logic [15:0] sp_data;
  logic        t_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk     (clk),
    .rst     (rst_n),
    .wb_en   (wb_en),
    .wb_reg  (wb_reg),
    .wb_data (wb_data),
    .rx_addr (rx_addr),
    .ry_addr (ry_addr),
    .rx_data (rx_data),
    .ry_data (ry_data),
    .ih_data (ih_data),
    .sp_data (sp_data),
    .t_flag  (t_flag)
  );

  typedef struct {
    logic        en;
    logic [3:0]  wreg;
    logic [15:0] wdata;
    logic [3:0]  rx;
    logic [3:0]  ry;
    logic [15:0] exp_rx;
    logic [15:0] exp_ry;
    logic [15:0] exp_ih;
    logic [15:0] exp_sp;
    logic        exp_t;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] rx;
    logic [15:0] ry;
    logic [15:0] ih;
    logic [15:0] sp;
    logic        tf;
  } obs_t;

  obs_t sb[$];
  vec_t vecs[18];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] wr, input logic [15:0] wd,
                       input logic [3:0] rx, input logic [3:0] ry);
    wb_en = en; wb_reg = wr; wb_data = wd; rx_addr = rx; ry_addr = ry;
  endtask

  initial begin
    obs_t o;
    vecs[0]  = '{1'b1, 4'd5,  16'hBEEF, 4'd5,  4'd0,  16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 4'd5,  16'h0000, 4'd5,  4'd5,  16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 4'd2,  16'h00A5, 4'd2,  4'd2,  16'h00A5, 16'h00A5, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 4'd4,  16'h7777, 4'd2,  4'd4,  16'h00A5, 16'h7777, 16'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 4'd4,  16'h0000, 4'd2,  4'd4,  16'h00A5, 16'h7777, 16'h0000, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 4'd15, 16'hFFFF, 4'd15, 4'd13, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd2,  16'hBEEF, 16'h00A5, 16'h0000, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 4'd1,  16'h0001, 4'd1,  4'd1,  16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0};
    vecs[8]  = '{1'b0, 4'd1,  16'h5555, 4'd1,  4'd1,  16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 4'd1,  16'h5555, 4'd1,  4'd0,  16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 4'd12, 16'h1111, 4'd12, 4'd0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 4'd8,  16'hABCD, 4'd8,  4'd9,  16'hABCD, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[12] = '{1'b0, 4'd0,  16'h0000, 4'd8,  4'd8,  16'hABCD, 16'hABCD, 16'h0000, 16'hABCD, 1'b0};
    vecs[13] = '{1'b1, 4'd9,  16'h8000, 4'd9,  4'd9,  16'h8000, 16'h8000, 16'h0000, 16'hABCD, 1'b0};
    vecs[14] = '{1'b0, 4'd0,  16'h0000, 4'd9,  4'd11, 16'h8000, 16'h0000, 16'h8000, 16'hABCD, 1'b0};
    vecs[15] = '{1'b1, 4'd11, 16'h0003, 4'd11, 4'd10, 16'h0003, 16'h0000, 16'h8000, 16'hABCD, 1'b0};
    vecs[16] = '{1'b1, 4'd10, 16'h0F0F, 4'd11, 4'd10, 16'h0003, 16'h0F0F, 16'h8000, 16'hABCD, 1'b1};
    vecs[17] = '{1'b0, 4'd0,  16'h0000, 4'd10, 4'd3,  16'h0F0F, 16'h0000, 16'h8000, 16'hABCD, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd3);
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx", rx_data, 16'h0000);
    check("reset_ih", ih_data, 16'h0000);
    check("reset_sp", sp_data, 16'h0000);
    check("reset_t",  {15'd0, t_flag}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: drive on the falling edge, push expectations, sample combinationally, commit at rising edge.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].en, vecs[i].wreg, vecs[i].wdata, vecs[i].rx, vecs[i].ry);
      sb.push_back('{i, vecs[i].exp_rx, vecs[i].exp_ry, vecs[i].exp_ih, vecs[i].exp_sp, vecs[i].exp_t});
      #2;
      o = sb.pop_front();
      check($sformatf("v%0d_rx", o.idx), rx_data, o.rx);
      check($sformatf("v%0d_ry", o.idx), ry_data, o.ry);
      check($sformatf("v%0d_ih", o.idx), ih_data, o.ih);
      check($sformatf("v%0d_sp", o.idx), sp_data, o.sp);
      check($sformatf("v%0d_t",  o.idx), {15'd0, t_flag}, {15'd0, o.tf});
      @(negedge clk);
    end

    // Mid-run asynchronous reset after R3 = 1234.
    drive(1'b1, 4'd3, 16'h1234, 4'd3, 4'd9);
    @(negedge clk);
    drive(1'b0, 4'd0, 16'h0000, 4'd3, 4'd9);
    #1;
    check("r3_before_reset", rx_data, 16'h1234);
    #1;
    rst_n = 1'b0;
    #1;
    check("r3_async_clear", rx_data, 16'h0000);
    check("ih_async_clear", ih_data, 16'h0000);
    check("sp_async_clear", sp_data, 16'h0000);
    check("t_async_clear",  {15'd0, t_flag}, 16'h0000);
    // A write presented during reset bypasses but is not stored.
    drive(1'b1, 4'd6, 16'h6666, 4'd6, 4'd3);
    #1;
    check("bypass_in_reset", rx_data, 16'h6666);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 4'd0, 16'h0000, 4'd6, 4'd3);
    #1;
    check("write_lost_in_reset", rx_data, 16'h0000);
    rst_n = 1'b1;

    // First write after release lands at the first rising edge.
    drive(1'b1, 4'd7, 16'h4242, 4'd7, 4'd6);
    @(posedge clk);
    #1;
    drive(1'b0, 4'd0, 16'h0000, 4'd7, 4'd6);
    #1;
    check("first_write_r7", rx_data, 16'h4242);
    check("r6_still_zero",  ry_data, 16'h0000);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
